bcd_counter_bank: RTL and testbench
===================================

Name: bcd_counter_bank

Overview:
- Multi-digit BCD counter bank that consumes the increment and refresh pulses of the upstream debounce/trigger stage.
- Each digit has its own select bit. On an increment pulse, every selected digit is incremented by one.
- Carries ripple sequentially, one digit per clock, so the whole scan finishes inside the upstream 16-cycle calculation window.
- On a refresh pulse, the working value is copied into a stable display register for the downstream display driver.

Parameters:
- DIGITS, 6, number of BCD digits. Legal range 1..15, so the scan always completes before the upstream refresh pulse.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inc_pulse  in  1  single-cycle increment strobe from the upstream stage
- inc_sel  in  DIGITS  per-digit increment mask; sampled only on the edge where inc_pulse=1
- ref_pulse  in  1  single-cycle refresh strobe from the upstream stage
- clear  in  1  synchronous clear of the working count
- count_out  out  4*DIGITS  display snapshot; digit i occupies bits [4i+3:4i]
- busy  out  1  high while the carry scan is in progress
- overflow  out  1  sticky; set on carry out of the top digit

Behaviour:
- Reset (async): working digits=0, count_out=0, busy=0, overflow=0, mask=0, carry=0, ref_pending=0, state=IDLE.
- States: IDLE and SCAN. Scan index idx has width clog2(DIGITS+1).
- IDLE:
  - On inc_pulse=1: latch mask<=inc_sel, carry<=0, idx<=0, go to SCAN.
  - If inc_sel=0, still run the scan; it is a no-op.
- SCAN, per edge, for digit d=idx:
  - sum = digit[d] + mask[d] + carry, range 0..11.
  - If sum>=10: digit[d]<=sum-10, carry<=1. Else digit[d]<=sum, carry<=0.
  - idx<=idx+1.
  - After digit DIGITS-1: if its carry is 1, overflow<=1 (top digit has already wrapped). Go to IDLE.
- Latency:
  - inc_pulse sampled at edge E0. Digit i is updated at edge E(i+1).
  - busy=1 from after E0 through edge E(DIGITS); busy=0 after E(DIGITS).
  - Total DIGITS cycles. With DIGITS<=15 this fits inside the upstream ref delay of 17 edges.
- busy is registered and equals (state==SCAN).
- inc_pulse while in SCAN: ignored. No queueing, no state change.
- ref_pulse:
  - In IDLE with no scan starting: count_out<=working digits at that edge.
  - In SCAN, or on the same edge inc_pulse starts a scan: set ref_pending.
  - When the scan finishes, count_out<=final digits on the first IDLE edge, then ref_pending<=0.
  - count_out never shows a partially carried value.
- clear (priority over everything except reset):
  - Working digits<=0, overflow<=0, mask<=0, carry<=0, state<=IDLE.
  - ref_pending is kept and is serviced on the next edge with zeros.
  - inc_pulse on the same edge is ignored. An in-progress scan is aborted.
  - count_out is unchanged until the next refresh.
- Digit values never leave 0..9 through counting; non-BCD values are unreachable.
- overflow is cleared only by reset or clear.

Decomposition:
- Shared package bcd_pkg:
  - DIGIT_W=4, BCD_MAX=4'd9.
  - State encoding localparams ST_IDLE, ST_SCAN.
  - Helper constant for the idx width.
- One sub-module, bcd_digit_add: combinational.
  - Inputs: 4-bit value, inc bit, carry_in.
  - Outputs: 4-bit result, carry_out.
  - Instantiated once and muxed by idx.
- The top level holds the FSM, the digit register array, the snapshot register, and the ref_pending logic.

Test Plan (DIGITS=6):
1. Assert reset mid-scan → count_out=0x000000, busy=0, overflow=0 immediately, without waiting for a clock.
2. inc_sel=6'b000001 with inc_pulse; ref_pulse 17 cycles later → busy high for exactly 6 cycles; count_out=0x000001.
3. Preload working value 000099 through repeated increments, then inc_sel=6'b000011 → digit0: 9+1=0 with carry, digit1: 9+1+1=1 with carry, digit2=1; after ref, count_out=0x000110.
4. Working value 999999, inc_sel=6'b000001 → all digits 0, overflow=1 after edge E6; a further increment leaves overflow=1.
5. ref_pulse two cycles after inc_pulse (value 000009, sel bit0) → count_out holds the old value during the scan, then becomes 0x000010 one edge after busy falls; never 0x000000 mid-carry.
6. clear asserted at scan edge E3 together with inc_pulse → digits=0, overflow=0, busy=0 next cycle, no new scan started; count_out is unchanged until the next ref_pulse, then shows 0x000000.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared constants for the BCD counter bank: digit width, BCD limit, FSM encoding.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SCAN = 1'b1;

    // Scan index must hold 0..digits so the last digit can be compared cleanly.
    function automatic int idx_width(input int digits);
        return $clog2(digits + 1);
    endfunction

endpackage

// File: rtl/bcd_digit_add.sv
// One-digit BCD adder: value + inc + carry_in, wrapping at ten.
module bcd_digit_add
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] value_i,
    input  logic               inc_i,
    input  logic               carry_i,
    output logic [DIGIT_W-1:0] result_o,
    output logic               carry_o
);

    logic [DIGIT_W-1:0] sum;

    always_comb begin
        sum = value_i + DIGIT_W'(inc_i) + DIGIT_W'(carry_i);
        if (sum > BCD_MAX) begin
            // sum is 10 or 11 here; adding 6 modulo 16 subtracts 10
            result_o = sum + 4'd6;
            carry_o  = 1'b1;
        end else begin
            result_o = sum;
            carry_o  = 1'b0;
        end
    end

endmodule

// File: rtl/bcd_counter_bank.sv
// Multi-digit BCD counter with a one-digit-per-clock carry scan and a refresh snapshot.
module bcd_counter_bank
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 6
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      inc_pulse,
    input  logic [DIGITS-1:0]         inc_sel,
    input  logic                      ref_pulse,
    input  logic                      clear,
    output logic [DIGIT_W*DIGITS-1:0] count_out,
    output logic                      busy,
    output logic                      overflow
);

    localparam int IDX_W = idx_width(int'(DIGITS));
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

    logic [0:0]                         state_q, state_d;
    logic [IDX_W-1:0]                   idx_q, idx_d;
    logic [DIGITS-1:0]                  mask_q, mask_d;
    logic                               carry_q, carry_d;
    logic [DIGITS-1:0][DIGIT_W-1:0]     digits_q, digits_d;
    logic [DIGITS-1:0][DIGIT_W-1:0]     count_q, count_d;
    logic                               overflow_q, overflow_d;
    logic                               ref_pending_q, ref_pending_d;

    logic [DIGIT_W-1:0] cur_digit;
    logic               cur_inc;
    logic [DIGIT_W-1:0] add_result;
    logic               add_carry;

    always_comb begin
        cur_digit = '0;
        cur_inc   = 1'b0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = digits_q[i];
                cur_inc   = mask_q[i];
            end
        end
    end

    bcd_digit_add u_digit_add (
        .value_i  (cur_digit),
        .inc_i    (cur_inc),
        .carry_i  (carry_q),
        .result_o (add_result),
        .carry_o  (add_carry)
    );

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        mask_d        = mask_q;
        carry_d       = carry_q;
        digits_d      = digits_q;
        count_d       = count_q;
        overflow_d    = overflow_q;
        ref_pending_d = ref_pending_q;

        if (clear) begin
            state_d    = ST_IDLE;
            idx_d      = '0;
            mask_d     = '0;
            carry_d    = 1'b0;
            digits_d   = '0;
            overflow_d = 1'b0;
            // A refresh coinciding with clear is deferred so it shows the cleared value
            if (ref_pulse) begin
                ref_pending_d = 1'b1;
            end
        end else if (state_q == ST_IDLE) begin
            if (ref_pending_q) begin
                count_d       = digits_q;
                ref_pending_d = 1'b0;
            end
            if (inc_pulse) begin
                state_d = ST_SCAN;
                idx_d   = '0;
                mask_d  = inc_sel;
                carry_d = 1'b0;
                if (ref_pulse) begin
                    ref_pending_d = 1'b1;
                end
            end else if (ref_pulse) begin
                count_d = digits_q;
            end
        end else begin
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (idx_q == IDX_W'(i)) begin
                    digits_d[i] = add_result;
                end
            end
            carry_d = add_carry;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
                state_d = ST_IDLE;
                if (add_carry) begin
                    overflow_d = 1'b1;
                end
            end
            if (ref_pulse) begin
                ref_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            mask_q        <= '0;
            carry_q       <= 1'b0;
            digits_q      <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            ref_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            mask_q        <= mask_d;
            carry_q       <= carry_d;
            digits_q      <= digits_d;
            count_q       <= count_d;
            overflow_q    <= overflow_d;
            ref_pending_q <= ref_pending_d;
        end
    end

    assign count_out = count_q;
    assign busy      = (state_q == ST_SCAN);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_bcd_counter_bank.sv
// Bench for bcd_counter_bank: constant vector tables, directed corner cases, and
// random traffic checked against a decimal-arithmetic reference model.
module tb_bcd_counter_bank;

    localparam int DIGITS = 6;
    localparam int MOD    = 1000000;

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    inc_pulse = 1'b0;
    logic [DIGITS-1:0]       inc_sel = '0;
    logic                    ref_pulse = 1'b0;
    logic                    clear = 1'b0;
    logic [4*DIGITS-1:0]     count_out;
    logic                    busy;
    logic                    overflow;

    int n_vec = 0;
    int n_err = 0;

    // Reference model: whole counter as an integer, scan as a countdown
    int m_val, m_snap, m_target, m_busy;
    bit m_ovf, m_tovf, m_pend;

    typedef struct {
        logic              inc;
        logic [DIGITS-1:0] sel;
        logic              rf;
        logic              clr;
        logic [23:0]       exp_cnt;
        logic              exp_busy;
        logic              exp_ovf;
    } vec_t;

    vec_t vt[16];

    bcd_counter_bank #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .reset     (reset),
        .inc_pulse (inc_pulse),
        .inc_sel   (inc_sel),
        .ref_pulse (ref_pulse),
        .clear     (clear),
        .count_out (count_out),
        .busy      (busy),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    function automatic int sel_value(input logic [DIGITS-1:0] sel);
        int v = 0;
        int p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            if (sel[i]) v += p;
            p *= 10;
        end
        return v;
    endfunction

    function automatic logic [23:0] to_bcd(input int val);
        logic [23:0] r = '0;
        int v = val;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_val = 0; m_snap = 0; m_target = 0; m_busy = 0;
        m_ovf = 0; m_tovf = 0; m_pend = 0;
    endtask

    task automatic model_edge();
        if (clear) begin
            m_val = 0;
            m_ovf = 0;
            m_busy = 0;
            if (ref_pulse) m_pend = 1;
        end else if (m_busy > 0) begin
            if (ref_pulse) m_pend = 1;
            m_busy--;
            if (m_busy == 0) begin
                m_val = m_target;
                if (m_tovf) m_ovf = 1;
            end
        end else begin
            if (m_pend) begin
                m_snap = m_val;
                m_pend = 0;
            end
            if (inc_pulse) begin
                m_target = m_val + sel_value(inc_sel);
                m_tovf = (m_target >= MOD);
                if (m_tovf) m_target -= MOD;
                m_busy = DIGITS;
                if (ref_pulse) m_pend = 1;
            end else if (ref_pulse) begin
                m_snap = m_val;
            end
        end
    endtask

    task automatic check_model();
        chk("model_busy", 32'(busy), 32'(m_busy != 0));
        chk("model_overflow", 32'(overflow), 32'(m_ovf));
        chk("model_count", 32'(count_out), 32'(to_bcd(m_snap)));
    endtask

    // Drive one cycle of inputs, advance the model, sample 1 ns after the edge
    task automatic cycle(input logic inc, input logic [DIGITS-1:0] sel, input logic rf,
                         input logic clr);
        inc_pulse = inc;
        inc_sel   = sel;
        ref_pulse = rf;
        clear     = clr;
        model_edge();
        @(posedge clk);
        #1;
        inc_pulse = 1'b0;
        ref_pulse = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic idle();
        cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic run_inc(input logic [DIGITS-1:0] sel);
        cycle(1'b1, sel, 1'b0, 1'b0);
        check_model();
        for (int i = 0; i < DIGITS; i++) begin
            idle();
            check_model();
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #3;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_row(input int r);
        cycle(vt[r].inc, vt[r].sel, vt[r].rf, vt[r].clr);
        chk("tbl_count", 32'(count_out), 32'(vt[r].exp_cnt));
        chk("tbl_busy", 32'(busy), 32'(vt[r].exp_busy));
        chk("tbl_ovf", 32'(overflow), 32'(vt[r].exp_ovf));
        check_model();
    endtask

    initial begin
        // Single-increment latency, then late refresh
        vt[0] = '{1'b1, 6'b000001, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        for (int i = 1; i <= 5; i++) vt[i] = '{1'b0, 6'b0, 1'b0, 1'b0, 24'h000000, 1'b1, 1'b0};
        vt[6] = '{1'b0, 6'b0, 1'b0, 1'b0, 24'h000000, 1'b0, 1'b0};
        vt[7] = '{1'b0, 6'b0, 1'b1, 1'b0, 24'h000001, 1'b0, 1'b0};
        // 000009 + 1 with refresh two cycles into the scan
        vt[8]  = '{1'b1, 6'b000001, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 6'b0, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0};
        vt[10] = '{1'b0, 6'b0, 1'b1, 1'b0, 24'h000001, 1'b1, 1'b0};
        for (int i = 11; i <= 13; i++) vt[i] = '{1'b0, 6'b0, 1'b0, 1'b0, 24'h000001, 1'b1, 1'b0};
        vt[14] = '{1'b0, 6'b0, 1'b0, 1'b0, 24'h000001, 1'b0, 1'b0};
        vt[15] = '{1'b0, 6'b0, 1'b0, 1'b0, 24'h000010, 1'b0, 1'b0};

        model_reset();
        #12;
        do_reset();
        chk("reset_count", 32'(count_out), 32'h0);
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ovf", 32'(overflow), 32'h0);

        for (int r = 0; r < 8; r++) apply_row(r);
        for (int k = 0; k < 8; k++) run_inc(6'b000001);
        for (int r = 8; r < 16; r++) apply_row(r);

        // 000099 + 000011: ripple through two selected digits into a third
        do_reset();
        for (int k = 0; k < 9; k++) run_inc(6'b000011);
        run_inc(6'b000011);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("carry_chain", 32'(count_out), 32'h000110);

        // 999999 + 1: wrap and sticky overflow set at E6
        do_reset();
        for (int k = 0; k < 9; k++) run_inc(6'b111111);
        cycle(1'b1, 6'b000001, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) idle();
        chk("ovf_before_e6", 32'(overflow), 32'h0);
        idle();
        chk("ovf_at_e6", 32'(overflow), 32'h1);
        chk("busy_at_e6", 32'(busy), 32'h0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("wrap_count", 32'(count_out), 32'h000000);
        run_inc(6'b000001);
        chk("ovf_sticky", 32'(overflow), 32'h1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("post_wrap_count", 32'(count_out), 32'h000001);

        // clear with inc_pulse at scan edge E3
        cycle(1'b1, 6'b000001, 1'b0, 1'b0);
        idle();
        idle();
        cycle(1'b1, 6'b000001, 1'b0, 1'b1);
        chk("clear_busy", 32'(busy), 32'h0);
        chk("clear_ovf", 32'(overflow), 32'h0);
        chk("clear_count_held", 32'(count_out), 32'h000001);
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("clear_no_scan", 32'(busy), 32'h0);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("clear_ref_count", 32'(count_out), 32'h000000);
        check_model();

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic c, f;
            c = ($urandom_range(0, 31) == 0);
            f = !c && ($urandom_range(0, 3) == 0);
            cycle(($urandom_range(0, 2) == 0), DIGITS'($urandom), f, c);
            check_model();
        end

        // Asynchronous reset in the middle of a scan
        do_reset();
        run_inc(6'b000001);
        cycle(1'b0, '0, 1'b1, 1'b0);
        chk("pre_async_count", 32'(count_out), 32'h000001);
        cycle(1'b1, 6'b000001, 1'b0, 1'b0);
        idle();
        #2;
        reset = 1'b1;
        #1;
        chk("async_count", 32'(count_out), 32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_ovf", 32'(overflow), 32'h0);
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
